fetch_stage: RTL

//  Instruction-fetch stage: owns the PC, issues fetches on a ready/valid instruction-memory port, and drives the IF/ID register.
//  The IF/ID register feeds PC4D/InstructionD to the decode stage.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a ready/valid instruction-memory
// port and the IF/ID register, honouring decode redirects and load-use stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isLWHazard,
  input  logic [1:0]  PCSourceD,
  input  logic [31:0] PC_B,
  input  logic [31:0] PC_J,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC4D,
  output logic [31:0] InstructionD,
  output logic [31:0] PCF
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pc4d, w_pc4d_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;

  logic        w_req;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  // Stall dominates: a redirect seen under a stall is dropped, and 2'b11 is sequential.
  assign w_redirect = ((PCSourceD == 2'b01) || (PCSourceD == 2'b10)) && !isLWHazard;
  assign w_target   = (PCSourceD == 2'b01) ? PC_B : PC_J;
  assign w_pc_inc   = r_pc + 32'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pc4d_nxt       = r_pc4d;
    w_instr_nxt      = r_instr;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_skid_instr_nxt = r_skid_instr;
    w_tgt_nxt        = r_tgt;
    w_req            = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (w_redirect) begin
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = w_target;
          end else if (isLWHazard) begin
            // Decode cannot accept: park the completed fetch until the stall clears.
            w_skid_pc4_nxt   = w_pc_inc;
            w_skid_instr_nxt = imem_rdata;
            w_pc_nxt         = w_pc_inc;
            w_state_nxt      = S_HOLD;
          end else begin
            w_pc4d_nxt  = w_pc_inc;
            w_instr_nxt = imem_rdata;
            w_pc_nxt    = w_pc_inc;
          end
        end else begin
          if (w_redirect) begin
            // The request in flight keeps its address; its data is dropped in KILL.
            w_tgt_nxt   = w_target;
            w_instr_nxt = NOP_INSTR;
            w_state_nxt = S_KILL;
          end else if (!isLWHazard) begin
            w_instr_nxt = NOP_INSTR;
          end
        end
      end
      S_HOLD: begin
        if (!isLWHazard) begin
          if (w_redirect) begin
            w_instr_nxt = NOP_INSTR;
            w_pc_nxt    = w_target;
          end else begin
            w_pc4d_nxt  = r_skid_pc4;
            w_instr_nxt = r_skid_instr;
          end
          w_state_nxt = S_FETCH;
        end
      end
      S_KILL: begin
        w_req = 1'b1;
        if (!isLWHazard) w_instr_nxt = NOP_INSTR;
        if (imem_ready) begin
          w_pc_nxt    = r_tgt;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pc4d       <= 32'h0;
      r_instr      <= NOP_INSTR;
      r_skid_pc4   <= 32'h0;
      r_skid_instr <= NOP_INSTR;
      r_tgt        <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pc4d       <= w_pc4d_nxt;
      r_instr      <= w_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_tgt        <= w_tgt_nxt;
    end
  end

  assign imem_req     = w_req && !reset;
  assign imem_addr    = r_pc;
  assign PCF          = r_pc;
  assign PC4D         = r_pc4d;
  assign InstructionD = r_instr;

endmodule
